sdram_rr_arbiter: RTL and testbench

Two-requester Avalon-MM arbiter placed in front of the SDRAM controller slave (16-bit data, 13-bit row, 2-bit bank, 10-bit column, so 25-bit word address). Shares the single SDRAM port between two local masters, for example a pattern generator and a checker, using round-robin grants. Supports pipelined reads: an in-order tag FIFO routes each returning readdata to the requester that issued it.

---
 rtl/sdram_arb_pkg.sv | 19 +
 rtl/sdram_arb_tag_fifo.sv | 66 ++++++
 rtl/sdram_rr_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_sdram_rr_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// ---------------------------------------------------------------------------
// sdram_arb_pkg
// Shared defaults and types for the two-requester SDRAM arbiter.
//   DEF_ADDR_W   : word address width (13 row + 2 bank + 10 column bits)
//   DEF_DATA_W   : SDRAM data width
//   DEF_BE_W     : byteenable width
//   DEF_MAX_PEND : outstanding reads tracked by the tag FIFO (power of 2)
//   req_id_t     : requester identifier stored in the tag FIFO
// ---------------------------------------------------------------------------
package sdram_arb_pkg;

  localparam int DEF_ADDR_W   = 25;
  localparam int DEF_DATA_W   = 16;
  localparam int DEF_BE_W     = 2;
  localparam int DEF_MAX_PEND = 8;

  typedef logic req_id_t;

endpackage : sdram_arb_pkg

// File: rtl/sdram_arb_tag_fifo.sv
// ---------------------------------------------------------------------------
// sdram_arb_tag_fifo
// In-order FIFO of requester ids. One entry is pushed per accepted read and
// popped per returning readdatavalid, so the head always names the requester
// that owns the next response.
// Ports:
//   clk, reset : clock, synchronous active-high reset (empties the FIFO)
//   push, din  : write request and requester id (ignored while full, even
//                when a pop happens in the same cycle)
//   pop, dout  : read request and head entry (dout valid while !empty)
//   full/empty : occupancy flags
// ---------------------------------------------------------------------------
module sdram_arb_tag_fifo
  import sdram_arb_pkg::*;
#(
  parameter int DEPTH = DEF_MAX_PEND
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  logic    pop,
  input  req_id_t din,
  output req_id_t dout,
  output logic    full,
  output logic    empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  req_id_t          mem_q [DEPTH];

  logic push_ok;
  logic pop_ok;

  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule : sdram_arb_tag_fifo

// File: rtl/sdram_rr_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_rr_arbiter
// Round-robin arbiter sharing one Avalon-MM SDRAM controller port between two
// masters. Commands pass through combinationally; read responses are routed
// back one cycle later using an in-order tag FIFO.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   m0_* / m1_*          : Avalon-MM slave ports facing the two requesters
//                          (address, read, write, writedata, byteenable,
//                          waitrequest, readdata, readdatavalid)
//   s_*                  : Avalon-MM master port to the SDRAM controller
//   rdv_err              : sticky, readdatavalid seen with nothing pending
//   gnt_cnt0/gnt_cnt1    : saturating accepted-command counters, present only
//                          when SDRAM_ARB_STATS_EN is defined
// ---------------------------------------------------------------------------
module sdram_rr_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int BE_W     = DEF_BE_W,
  parameter int MAX_PEND = DEF_MAX_PEND
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic [BE_W-1:0]   m0_byteenable,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic [BE_W-1:0]   m1_byteenable,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] s_address,
  output logic              s_read,
  output logic              s_write,
  output logic [DATA_W-1:0] s_writedata,
  output logic [BE_W-1:0]   s_byteenable,
  input  logic              s_waitrequest,
  input  logic [DATA_W-1:0] s_readdata,
  input  logic              s_readdatavalid,
  output logic              rdv_err
`ifdef SDRAM_ARB_STATS_EN
  ,
  output logic [15:0]       gnt_cnt0,
  output logic [15:0]       gnt_cnt1
`endif
);

  // Grant state
  req_id_t last_grant_q, last_grant_d;
  req_id_t cur_q, cur_d;
  logic    lock_q, lock_d;

  // Command path
  logic    req0, req1;
  req_id_t sel;
  logic    sel_rd, sel_wr;
  logic    rd_blocked;
  logic    accept;
  logic    stall;

  // Tag FIFO
  logic    fifo_full, fifo_empty;
  req_id_t fifo_tag;
  logic    rsp_pop;

  // Per-requester response registers
  logic              rdv_q   [2];
  logic [DATA_W-1:0] rdata_q [2];
  logic              rdv_err_q;

  always_comb begin
    req0 = m0_read | m0_write;
    req1 = m1_read | m1_write;

    // A stalled master holds its command, so a locked grant stays put.
    if (lock_q)           sel = cur_q;
    else if (req0 & req1) sel = ~last_grant_q;
    else if (req1)        sel = 1'b1;
    else                  sel = 1'b0;

    // Read wins when a master illegally asserts both.
    sel_rd     = sel ? m1_read  : m0_read;
    sel_wr     = (sel ? m1_write : m0_write) & ~sel_rd;
    rd_blocked = sel_rd & fifo_full;

    s_read       = ~reset & sel_rd & ~fifo_full;
    s_write      = ~reset & sel_wr;
    s_address    = sel ? m1_address    : m0_address;
    s_writedata  = sel ? m1_writedata  : m0_writedata;
    s_byteenable = sel ? m1_byteenable : m0_byteenable;

    m0_waitrequest = reset | sel  | s_waitrequest | rd_blocked;
    m1_waitrequest = reset | ~sel | s_waitrequest | rd_blocked;

    accept = (s_read | s_write) & ~s_waitrequest;
    stall  = (s_read | s_write) & s_waitrequest;

    last_grant_d = accept ? sel : last_grant_q;
    cur_d        = stall ? sel : cur_q;
    if (accept)     lock_d = 1'b0;
    else if (stall) lock_d = 1'b1;
    else            lock_d = lock_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      cur_q        <= 1'b0;
      lock_q       <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      cur_q        <= cur_d;
      lock_q       <= lock_d;
    end
  end

  sdram_arb_tag_fifo #(
    .DEPTH (MAX_PEND)
  ) u_tag_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (s_read & ~s_waitrequest),
    .pop   (s_readdatavalid),
    .din   (sel),
    .dout  (fifo_tag),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rsp_pop = s_readdatavalid & ~fifo_empty;

  // Responses are steered by the tag at the FIFO head; a requester's
  // readdata only updates when one of its own responses arrives.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
      always_ff @(posedge clk) begin
        if (reset) begin
          rdv_q[gi]   <= 1'b0;
          rdata_q[gi] <= '0;
        end else begin
          rdv_q[gi] <= rsp_pop & (fifo_tag == req_id_t'(gi));
          if (rsp_pop & (fifo_tag == req_id_t'(gi))) rdata_q[gi] <= s_readdata;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) rdv_err_q <= 1'b0;
    else       rdv_err_q <= rdv_err_q | (s_readdatavalid & fifo_empty);
  end

  assign m0_readdatavalid = rdv_q[0];
  assign m1_readdatavalid = rdv_q[1];
  assign m0_readdata      = rdata_q[0];
  assign m1_readdata      = rdata_q[1];
  assign rdv_err          = rdv_err_q;

`ifdef SDRAM_ARB_STATS_EN
  logic [15:0] gnt_cnt_q [2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_stats
      always_ff @(posedge clk) begin
        if (reset) begin
          gnt_cnt_q[gi] <= '0;
        end else if (accept && (sel == req_id_t'(gi)) && (gnt_cnt_q[gi] != 16'hFFFF)) begin
          gnt_cnt_q[gi] <= gnt_cnt_q[gi] + 16'd1;
        end
      end
    end
  endgenerate

  assign gnt_cnt0 = gnt_cnt_q[0];
  assign gnt_cnt1 = gnt_cnt_q[1];
`endif

endmodule : sdram_rr_arbiter

// File: tb/tb_sdram_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sdram_rr_arbiter
// Directed checks of the two-requester SDRAM arbiter: reset state, write
// pass-through, round-robin ties, read precedence, alternating pipelined
// reads with response routing, stall locking, tag FIFO full/free boundary,
// and late responses after reset. Stats counters checked when
// SDRAM_ARB_STATS_EN is defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sdram_rr_arbiter;

  logic        clk;
  logic        reset;
  logic [24:0] m0_address, m1_address, s_address;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [15:0] m0_writedata, m1_writedata, s_writedata;
  logic [1:0]  m0_byteenable, m1_byteenable, s_byteenable;
  logic        m0_waitrequest, m1_waitrequest;
  logic [15:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic        s_read, s_write, s_waitrequest, s_readdatavalid;
  logic [15:0] s_readdata;
  logic        rdv_err;
`ifdef SDRAM_ARB_STATS_EN
  logic [15:0] gnt_cnt0, gnt_cnt1;
`endif

  int n_vec = 0;
  int n_err = 0;

  sdram_rr_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .m0_address       (m0_address),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
    .m0_byteenable    (m0_byteenable),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m1_address),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_writedata     (m1_writedata),
    .m1_byteenable    (m1_byteenable),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .s_address        (s_address),
    .s_read           (s_read),
    .s_write          (s_write),
    .s_writedata      (s_writedata),
    .s_byteenable     (s_byteenable),
    .s_waitrequest    (s_waitrequest),
    .s_readdata       (s_readdata),
    .s_readdatavalid  (s_readdatavalid),
    .rdv_err          (rdv_err)
`ifdef SDRAM_ARB_STATS_EN
    ,
    .gnt_cnt0         (gnt_cnt0),
    .gnt_cnt1         (gnt_cnt1)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; outputs are sampled on the
  // falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_masters();
    m0_read = 1'b0; m0_write = 1'b0;
    m1_read = 1'b0; m1_write = 1'b0;
  endtask

  initial begin
    int n0;
    int n1;
    int exp_sel;

    reset = 1'b1;
    idle_masters();
    m0_address = '0; m1_address = '0;
    m0_writedata = '0; m1_writedata = '0;
    m0_byteenable = 2'b11; m1_byteenable = 2'b11;
    s_waitrequest = 1'b0; s_readdatavalid = 1'b0; s_readdata = '0;

    // ---- reset state -------------------------------------------------------
    repeat (2) step();
    m0_read = 1'b1;
    @(negedge clk);
    chk("rst_s_read",   32'(s_read), 32'd0);
    chk("rst_s_write",  32'(s_write), 32'd0);
    chk("rst_m0_wait",  32'(m0_waitrequest), 32'd1);
    chk("rst_m1_wait",  32'(m1_waitrequest), 32'd1);
    chk("rst_rdv_err",  32'(rdv_err), 32'd0);
    chk("rst_m0_rdv",   32'(m0_readdatavalid), 32'd0);
    chk("rst_m1_rdv",   32'(m1_readdatavalid), 32'd0);
    chk("rst_m0_rdata", 32'(m0_readdata), 32'd0);
    $display("reset: state checked");

    // ---- single m0 write ---------------------------------------------------
    step();
    reset = 1'b0;
    m0_read = 1'b0;
    m0_write = 1'b1; m0_address = 25'h0000010; m0_writedata = 16'hA5A5;
    @(negedge clk);
    chk("wr_s_write", 32'(s_write), 32'd1);
    chk("wr_s_read",  32'(s_read), 32'd0);
    chk("wr_s_addr",  32'(s_address), 32'h10);
    chk("wr_s_wdata", 32'(s_writedata), 32'hA5A5);
    chk("wr_m0_wait", 32'(m0_waitrequest), 32'd0);
    chk("wr_m1_wait", 32'(m1_waitrequest), 32'd1);
    $display("write m0 addr=0x10 data=0xA5A5");

    // ---- ties: last_grant=0 so m1 wins, then m0 -----------------------------
    step();
    m0_address = 25'h20; m0_writedata = 16'h1111;
    m1_write = 1'b1; m1_address = 25'h30; m1_writedata = 16'h2222;
    @(negedge clk);
    chk("tie1_s_addr",  32'(s_address), 32'h30);
    chk("tie1_s_wdata", 32'(s_writedata), 32'h2222);
    chk("tie1_m0_wait", 32'(m0_waitrequest), 32'd1);
    chk("tie1_m1_wait", 32'(m1_waitrequest), 32'd0);
    $display("tie write -> m1");
    step();
    @(negedge clk);
    chk("tie2_s_addr", 32'(s_address), 32'h20);
    $display("tie write -> m0");

    // ---- read+write on m0: read takes precedence ----------------------------
    step();
    m1_write = 1'b0;
    m0_read = 1'b1; m0_write = 1'b1;
    @(negedge clk);
    chk("rw_s_read",  32'(s_read), 32'd1);
    chk("rw_s_write", 32'(s_write), 32'd0);
    $display("m0 read+write -> read");
    step();
    idle_masters();
    reset = 1'b1;
    step();
    reset = 1'b0;

    // ---- alternating reads, 8 in 8 cycles -----------------------------------
    n0 = 0; n1 = 0;
    for (int i = 0; i < 8; i++) begin
      m0_read = 1'b1; m1_read = 1'b1;
      m0_address = 25'h100 + 25'(n0);
      m1_address = 25'h200 + 25'(n1);
      @(negedge clk);
      exp_sel = i % 2;
      chk("rr_s_read", 32'(s_read), 32'd1);
      chk("rr_s_addr", 32'(s_address), (exp_sel == 0) ? 32'h100 + 32'(n0) : 32'h200 + 32'(n1));
      $display("rr read %0d grant m%0d addr=0x%0h", i, exp_sel, s_address);
      step();
      if (exp_sel == 0) n0++; else n1++;
    end
    idle_masters();
    // Responses back to back; routed 0,1,0,1 one cycle later.
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) step();
      s_readdatavalid = (i < 8);
      s_readdata = 16'hD000 + 16'(i);
      @(negedge clk);
      if (i > 0) begin
        chk("rr_rsp_rdv_own",   32'(((i-1) % 2 == 0) ? m0_readdatavalid : m1_readdatavalid), 32'd1);
        chk("rr_rsp_rdv_other", 32'(((i-1) % 2 == 0) ? m1_readdatavalid : m0_readdatavalid), 32'd0);
        chk("rr_rsp_data",      32'(((i-1) % 2 == 0) ? m0_readdata : m1_readdata), 32'hD000 + 32'(i-1));
        $display("rr response %0d -> m%0d", i-1, (i-1) % 2);
      end
    end
    step();
    s_readdatavalid = 1'b0;

    // ---- m1 stalled 3 cycles, m0 arrives mid-stall --------------------------
    m1_read = 1'b1; m1_address = 25'h333;
    s_waitrequest = 1'b1;
    @(negedge clk);
    chk("stall0_s_addr",  32'(s_address), 32'h333);
    chk("stall0_m1_wait", 32'(m1_waitrequest), 32'd1);
    for (int c = 1; c <= 3; c++) begin
      step();
      m0_read = 1'b1; m0_address = 25'h444;
      s_waitrequest = (c != 3);
      @(negedge clk);
      chk("stall_s_addr", 32'(s_address), 32'h333);
      chk("stall_m0_wait", 32'(m0_waitrequest), 32'd1);
      $display("stall cycle %0d s_addr=0x%0h", c, s_address);
    end
    chk("stall_m1_acc", 32'(m1_waitrequest), 32'd0);
    step();
    m1_read = 1'b0;
    @(negedge clk);
    chk("after_stall_addr",  32'(s_address), 32'h444);
    chk("after_stall_m0_wt", 32'(m0_waitrequest), 32'd0);
    $display("m0 granted after m1 accept");
    step();
    m0_read = 1'b0; s_waitrequest = 1'b0;
    s_readdatavalid = 1'b1; s_readdata = 16'hE001;
    step();
    s_readdata = 16'hE002;
    @(negedge clk);
    chk("stall_rsp1_m1", 32'({m1_readdatavalid, m1_readdata}), {15'd0, 1'b1, 16'hE001});
    step();
    s_readdatavalid = 1'b0;
    @(negedge clk);
    chk("stall_rsp2_m0", 32'({m0_readdatavalid, m0_readdata}), {15'd0, 1'b1, 16'hE002});
    $display("stall responses routed m1 then m0");

    // ---- fill tag FIFO with 8 m0 reads, 9th blocked -------------------------
    step();
    m0_read = 1'b1;
    for (int i = 0; i < 8; i++) begin
      m0_address = 25'h500 + 25'(i);
      @(negedge clk);
      chk("fill_s_read", 32'(s_read), 32'd1);
      step();
    end
    m0_address = 25'h508;
    @(negedge clk);
    chk("full_s_read",  32'(s_read), 32'd0);
    chk("full_m0_wait", 32'(m0_waitrequest), 32'd1);
    $display("9th read blocked by full FIFO");
    step();
    s_readdatavalid = 1'b1; s_readdata = 16'hF000;
    @(negedge clk);
    chk("full_pop_s_read", 32'(s_read), 32'd0);
    step();
    s_readdatavalid = 1'b0;
    @(negedge clk);
    chk("freed_s_read",  32'(s_read), 32'd1);
    chk("freed_m0_wait", 32'(m0_waitrequest), 32'd0);
    chk("freed_rsp",     32'({m0_readdatavalid, m0_readdata}), {15'd0, 1'b1, 16'hF000});
    $display("9th read accepted after one response");
    step();
    m0_read = 1'b0;
    s_readdatavalid = 1'b1;
    repeat (5) step();   // leaves 3 reads pending
    s_readdatavalid = 1'b0;

    // ---- reset with 3 pending, then late responses --------------------------
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("late_err_pre", 32'(rdv_err), 32'd0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      s_readdatavalid = (i < 3);
      @(negedge clk);
      if (i > 0) begin
        chk("late_m0_rdv", 32'(m0_readdatavalid), 32'd0);
        chk("late_m1_rdv", 32'(m1_readdatavalid), 32'd0);
      end
    end
    chk("late_rdv_err", 32'(rdv_err), 32'd1);
    $display("late responses after reset -> rdv_err=%0d", rdv_err);

`ifdef SDRAM_ARB_STATS_EN
    step();
    m0_write = 1'b1;
    repeat (5) step();
    m0_write = 1'b0; m1_write = 1'b1;
    repeat (2) step();
    m1_write = 1'b0;
    @(negedge clk);
    chk("stats_cnt0", 32'(gnt_cnt0), 32'd5);
    chk("stats_cnt1", 32'(gnt_cnt1), 32'd2);
    $display("stats cnt0=%0d cnt1=%0d", gnt_cnt0, gnt_cnt1);
    step();
    m0_write = 1'b1;
    repeat (65535) step();
    m0_write = 1'b0;
    @(negedge clk);
    chk("stats_sat0", 32'(gnt_cnt0), 32'hFFFF);
    $display("stats cnt0 saturated at 0x%0h", gnt_cnt0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_sdram_rr_arbiter
